// File: rtl/tof_bram_write_arbiter.sv
// Round-robin scheduler sharing the ToF BRAM write port among N_SENS channels.
// Counts zones per sensor and flips the ping-pong bank when a full frame has landed.
module tof_bram_write_arbiter #(
   parameter int unsigned N_SENS = 8,
   parameter int unsigned IDX_W  = 3,
   parameter int unsigned ZONE_W = 6,
   parameter int unsigned DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_SENS-1:0]        tof_req,
   input  logic [ZONE_W+DATA_W-1:0] tof_rec,
   output logic [IDX_W-1:0]         tof_sel,
   output logic [N_SENS-1:0]        tof_ack,
   output logic                     bram_we,
   output logic [IDX_W+ZONE_W:0]    bram_addr,
   output logic [DATA_W-1:0]        bram_din,
   input  logic                     reader_busy,
   output logic                     frame_done,
   output logic                     frame_bank,
   output logic                     overrun
);

   localparam logic [ZONE_W:0]   ZONES   = {1'b1, {ZONE_W{1'b0}}};
   localparam logic [N_SENS-1:0] ACK_ONE = {{(N_SENS-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, SEL, WRITE, FLIP} state_t;

   state_t            state;
   logic [IDX_W-1:0]  rr_ptr;
   logic              bank;
   logic [ZONE_W:0]   cnt [N_SENS];
   logic [N_SENS-1:0] done_mask;
   logic [N_SENS-1:0] eligible;
   logic              grant_vld;
   logic [IDX_W-1:0]  grant_idx;
   logic [IDX_W-1:0]  cand;

   // Scan from the farthest offset back to rr_ptr so the nearest eligible channel wins.
   always_comb begin
      done_mask = '0;
      cand      = '0;
      for (int unsigned i = 0; i < N_SENS; i++) begin
         done_mask[i] = (cnt[i] == ZONES);
      end
      eligible  = tof_req & ~done_mask;
      grant_vld = |eligible;
      grant_idx = rr_ptr;
      for (int unsigned k = N_SENS; k > 0; k--) begin
         cand = rr_ptr + IDX_W'(k - 1);
         if (eligible[cand]) grant_idx = cand;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         bank       <= 1'b0;
         tof_sel    <= '0;
         tof_ack    <= '0;
         bram_we    <= 1'b0;
         bram_addr  <= '0;
         bram_din   <= '0;
         frame_done <= 1'b0;
         frame_bank <= 1'b0;
         overrun    <= 1'b0;
         for (int unsigned i = 0; i < N_SENS; i++) cnt[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  tof_sel <= grant_idx;
                  state   <= SEL;
               end
            end
            // Record is captured at the end of SEL so the write strobe is registered in WRITE.
            SEL: begin
               bram_we   <= 1'b1;
               bram_addr <= {bank, tof_sel, tof_rec[ZONE_W+DATA_W-1:DATA_W]};
               bram_din  <= tof_rec[DATA_W-1:0];
               tof_ack   <= ACK_ONE << tof_sel;
               if (cnt[tof_sel] != ZONES) cnt[tof_sel] <= cnt[tof_sel] + 1'b1;
               rr_ptr    <= tof_sel + 1'b1;
               state     <= WRITE;
            end
            WRITE: begin
               bram_we <= 1'b0;
               tof_ack <= '0;
               if (&done_mask) begin
                  frame_done <= 1'b1;
                  frame_bank <= bank;
                  overrun    <= reader_busy;
                  if (!reader_busy) bank <= ~bank;
                  state      <= FLIP;
               end else begin
                  state <= IDLE;
               end
            end
            FLIP: begin
               frame_done <= 1'b0;
               overrun    <= 1'b0;
               for (int unsigned i = 0; i < N_SENS; i++) cnt[i] <= '0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
